// File: rtl/usb_buff_pkg.sv
// Shared sizing constants and reader FSM state encoding for the USB buffer reader.
package usb_buff_pkg;

  localparam int USB_HALF_DEPTH = 128;
  localparam int USB_ADDR_W     = 8;
  localparam int USB_DATA_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/usb_skid_fifo.sv
// Two-entry holding FIFO between the buffer read port and the USB FIFO write port.
module usb_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/usb_buff_reader.sv
// Streams one completed half of the ping-pong USB buffer into the USB FIFO,
// starting whenever the writer's half-select flag toggles.
module usb_buff_reader
  import usb_buff_pkg::*;
#(
  parameter int HALF_DEPTH = USB_HALF_DEPTH,
  parameter int ADDR_W     = USB_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENA,
  input  logic                  BUFFREADY_USBTRANS,
  output logic [ADDR_W-1:0]     RADDR_USBBUFF,
  output logic                  RCLK_USBBUFF,
  output logic                  RENA_USBBUFF,
  input  logic [USB_DATA_W-1:0] DATA_OUT_USBBUFF,
  input  logic                  USB_TXE_N,
  output logic [USB_DATA_W-1:0] USB_DATA,
  output logic                  USB_WR,
  output logic                  BUSY,
  output logic                  OVERRUN
);

  localparam int                CNT_W      = $clog2(HALF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(HALF_DEPTH - 1);
  localparam logic [ADDR_W-1:0] UPPER_BASE = ADDR_W'(HALF_DEPTH);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              flag_q, flag_d;
  logic              prev_q, prev_d;
  logic              inflight_q, inflight_d;
  logic              ovr_q, ovr_d;

  logic              toggle, issue, flush, last_acc, usb_wr;
  logic              fifo_empty, fifo_push;
  logic [1:0]        fifo_cnt;
  logic [2:0]        load;

  assign toggle   = flag_q ^ prev_q;
  assign usb_wr   = !fifo_empty && !USB_TXE_N;
  // The byte leaving this edge frees its slot, which keeps one read per cycle.
  assign load     = 3'(fifo_cnt) + 3'(inflight_q) - 3'(usb_wr);
  assign issue    = ENA && (state_q == ST_XFER) && (load < 3'd2);
  assign last_acc = (state_q == ST_DRAIN) && usb_wr && (wr_cnt_q == LAST_IDX);
  assign fifo_push = inflight_q && ENA;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    ovr_d      = ovr_q;
    flag_d     = BUFFREADY_USBTRANS;
    prev_d     = flag_q;
    inflight_d = issue;
    flush      = 1'b0;

    if (usb_wr) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    if (issue) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
      if (rd_cnt_q == LAST_IDX) begin
        state_d = ST_DRAIN;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    if (!ENA) begin
      state_d    = ST_IDLE;
      flush      = 1'b1;
      inflight_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (toggle) begin
            state_d  = ST_XFER;
            addr_d   = flag_q ? '0 : UPPER_BASE;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
          end
        end
        ST_XFER: begin
          if (toggle) ovr_d = 1'b1;
        end
        ST_DRAIN: begin
          // A half completing on the final-byte edge is back-to-back, not an overrun.
          if (last_acc) begin
            if (toggle) begin
              state_d  = ST_XFER;
              addr_d   = flag_q ? '0 : UPPER_BASE;
              rd_cnt_d = '0;
              wr_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (toggle) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      flag_q     <= 1'b0;
      prev_q     <= 1'b0;
      inflight_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      flag_q     <= flag_d;
      prev_q     <= prev_d;
      inflight_q <= inflight_d;
      ovr_q      <= ovr_d;
    end
  end

  usb_skid_fifo #(
    .DATA_W(USB_DATA_W)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .flush    (flush),
    .push     (fifo_push),
    .push_data(DATA_OUT_USBBUFF),
    .pop      (usb_wr),
    .head     (USB_DATA),
    .count    (fifo_cnt),
    .empty    (fifo_empty)
  );

  assign RADDR_USBBUFF = addr_q;
  assign RENA_USBBUFF  = issue;
  assign RCLK_USBBUFF  = CLK & ENA;
  assign USB_WR        = usb_wr;
  assign BUSY          = (state_q != ST_IDLE);
  assign OVERRUN       = ovr_q;

endmodule

// File: tb/tb_usb_buff_reader.sv
// Self-checking bench for usb_buff_reader: byte-stream scoreboard built from half-buffer contents.
module tb_usb_buff_reader;

  logic       CLK = 1'b0;
  logic       RST, ENA, BUFFREADY_USBTRANS, USB_TXE_N;
  logic [7:0] RADDR_USBBUFF, USB_DATA;
  logic [7:0] DATA_OUT_USBBUFF = '0;
  logic       RCLK_USBBUFF, RENA_USBBUFF, USB_WR, BUSY, OVERRUN;

  always #5 CLK = ~CLK;

  usb_buff_reader dut (
    .CLK               (CLK),
    .RST               (RST),
    .ENA               (ENA),
    .BUFFREADY_USBTRANS(BUFFREADY_USBTRANS),
    .RADDR_USBBUFF     (RADDR_USBBUFF),
    .RCLK_USBBUFF      (RCLK_USBBUFF),
    .RENA_USBBUFF      (RENA_USBBUFF),
    .DATA_OUT_USBBUFF  (DATA_OUT_USBBUFF),
    .USB_TXE_N         (USB_TXE_N),
    .USB_DATA          (USB_DATA),
    .USB_WR            (USB_WR),
    .BUSY              (BUSY),
    .OVERRUN           (OVERRUN)
  );

  // Buffer RAM: one-cycle read latency.
  logic [7:0] ram [256];
  always @(posedge CLK) if (RENA_USBBUFF) DATA_OUT_USBBUFF <= ram[RADDR_USBBUFF];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int   rd_q[$];
  int   byte_q[$];
  bit   mon_en = 1'b0;
  bit   rst_v = 1'b1, ena_v = 1'b1, txe_v = 1'b0, br_v = 1'b0;
  int   cyc = 0, xfer_bytes = 0, acc_all = 0;
  int   first_wr = -1, last_wr = -1, tog_cyc = 0;
  int   last_data = 0;

  task automatic fill_ram(input logic [7:0] key);
    for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ key;
  endtask

  task automatic load_half(input bit lower);
    for (int i = 0; i < 128; i++) begin
      int a;
      a = lower ? i : 128 + i;
      rd_q.push_back(a);
      byte_q.push_back(int'(ram[a]));
    end
    xfer_bytes = 0;
    first_wr   = -1;
  endtask

  // Rising flag means the lower half is complete, falling means the upper half.
  task automatic toggle_start();
    br_v = !br_v;
    load_half(br_v);
    tog_cyc = cyc + 1;
  endtask

  task automatic tick();
    @(negedge CLK);
    RST = rst_v; ENA = ena_v; USB_TXE_N = txe_v; BUFFREADY_USBTRANS = br_v;
    #2;
    cyc++;
    if (mon_en) begin
      if (RENA_USBBUFF) begin
        if (rd_q.size() == 0) chk("extra_rd", RENA_USBBUFF, 0);
        else chk("raddr", RADDR_USBBUFF, rd_q.pop_front());
      end
      if (USB_WR) begin
        if (byte_q.size() == 0) chk("extra_wr", USB_WR, 0);
        else begin
          chk("byte", USB_DATA, byte_q.pop_front());
          xfer_bytes++;
          acc_all++;
          last_data = int'(USB_DATA);
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
        end
      end
    end
  endtask

  task automatic run_done(input int mode, input int budget);
    for (int k = 0; k < budget; k++) begin
      case (mode)
        0:       txe_v = 1'b0;
        1:       txe_v = (k % 3 == 2) || (k >= 40 && k < 50);
        default: txe_v = ($urandom_range(0, 3) == 0);
      endcase
      tick();
      if (byte_q.size() == 0 && rd_q.size() == 0 && BUSY == 1'b0) begin
        txe_v = 1'b0;
        return;
      end
    end
    chk("timeout", byte_q.size(), 0);
    byte_q.delete();
    rd_q.delete();
    txe_v = 1'b0;
  endtask

  task automatic run_until_bytes(input int n);
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (xfer_bytes >= n) return;
    end
    chk("timeout_n", xfer_bytes, n);
  endtask

  initial begin
    int base;
    bit hit;
    RST = 1'b1; ENA = 1'b1; USB_TXE_N = 1'b0; BUFFREADY_USBTRANS = 1'b1;

    // Reset state, with the flag already high so release must look like a rising toggle.
    fill_ram(8'h00);
    br_v = 1'b1; rst_v = 1'b1;
    repeat (3) tick();
    chk("rst_raddr", RADDR_USBBUFF, 0);
    chk("rst_rena", RENA_USBBUFF, 0);
    chk("rst_data", USB_DATA, 0);
    chk("rst_wr", USB_WR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovr", OVERRUN, 0);

    // Lower half after reset release, TXE always low.
    rst_v = 1'b0;
    load_half(1'b1);
    tog_cyc = cyc + 1;
    mon_en = 1'b1;
    run_done(0, 1000);
    chk("first_wr_lat_ok", (first_wr - tog_cyc) <= 5, 1);
    chk("burst_len", last_wr - first_wr + 1, 128);
    chk("lower_bytes", xfer_bytes, 128);
    chk("lower_last", last_data, 8'h7F);
    chk("lower_busy_end", BUSY, 0);

    // Upper half: addresses 0x80..0xFF only.
    toggle_start();
    run_done(0, 1000);
    chk("upper_bytes", xfer_bytes, 128);
    chk("upper_last", last_data, 8'hFF);
    chk("upper_busy_end", BUSY, 0);

    // Backpressure: TXE high every third cycle plus a 10-cycle burst.
    fill_ram(8'($urandom));
    toggle_start();
    run_done(1, 2000);
    chk("txe_bytes", xfer_bytes, 128);
    chk("txe_ovr", OVERRUN, 0);

    // Next half completes exactly on the edge accepting the last byte.
    toggle_start();
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      tick();
      if (byte_q.size() <= 2) hit = 1'b1;
    end
    chk("b2b_reach", hit, 1);
    base = acc_all;
    toggle_start();
    run_done(0, 1000);
    chk("b2b_bytes", acc_all - base, 130);
    chk("b2b_ovr", OVERRUN, 0);

    // Random backpressure and contents over several halves.
    for (int t = 0; t < 4; t++) begin
      fill_ram(8'($urandom));
      toggle_start();
      run_done(2, 3000);
      chk("rand_bytes", xfer_bytes, 128);
    end
    chk("rand_ovr", OVERRUN, 0);

    // Overrun: second half completes while byte 40 of the first is going out.
    toggle_start();
    run_until_bytes(40);
    br_v = !br_v;
    run_done(0, 1000);
    chk("ovr_set", OVERRUN, 1);
    chk("ovr_bytes", xfer_bytes, 128);
    repeat (10) tick();
    chk("ovr_no_more", xfer_bytes, 128);
    chk("ovr_idle", BUSY, 0);

    // Enable drop at byte 64, toggle while disabled, then a clean transfer.
    toggle_start();
    run_until_bytes(64);
    mon_en = 1'b0;
    ena_v  = 1'b0;
    tick();
    rd_q.delete();
    byte_q.delete();
    tick();
    chk("ena_busy", BUSY, 0);
    chk("ena_wr", USB_WR, 0);
    chk("ena_ovr_kept", OVERRUN, 1);
    br_v = !br_v;
    repeat (5) tick();
    mon_en = 1'b1;
    ena_v  = 1'b1;
    xfer_bytes = 0;
    repeat (8) tick();
    chk("ena_ignored_busy", BUSY, 0);
    chk("ena_ignored_bytes", xfer_bytes, 0);
    toggle_start();
    run_done(0, 1000);
    chk("ena_restart_bytes", xfer_bytes, 128);

    // Reset in the middle of a transfer.
    toggle_start();
    run_until_bytes(30);
    mon_en = 1'b0;
    rst_v  = 1'b1;
    br_v   = 1'b0;
    tick();
    chk("mrst_raddr", RADDR_USBBUFF, 0);
    chk("mrst_rena", RENA_USBBUFF, 0);
    chk("mrst_data", USB_DATA, 0);
    chk("mrst_wr", USB_WR, 0);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_ovr", OVERRUN, 0);
    rd_q.delete();
    byte_q.delete();
    tick();
    rst_v = 1'b0;
    mon_en = 1'b1;
    xfer_bytes = 0;
    repeat (10) tick();
    chk("mrst_quiet", xfer_bytes, 0);
    chk("mrst_quiet_busy", BUSY, 0);
    toggle_start();
    run_done(0, 1000);
    chk("mrst_restart_bytes", xfer_bytes, 128);
    chk("mrst_restart_last", last_data, 8'h7F ^ int'(ram[127]) ^ 8'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_buff_reader.md
USB_BUFF_READER -- requirements
Module: usb_buff_reader

Interface
REQ-001 Parameter HALF_DEPTH, default 128, bytes per ping-pong half of the 256-byte USB buffer.
REQ-002 Parameter ADDR_W, default 8, buffer address width.
REQ-003 CLK  input  1  system clock; all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 ENA  input  1  block enable; low aborts and idles.
REQ-006 BUFFREADY_USBTRANS  input  1  half-select flag from buffer writer; high = writer in upper half (lower half complete), low = writer in lower half (upper half complete).
REQ-007 RADDR_USBBUFF  output  8  buffer read address.
REQ-008 RCLK_USBBUFF  output  1  buffer read clock, equal to CLK when ENA high, 0 otherwise.
REQ-009 RENA_USBBUFF  output  1  buffer read enable, one cycle per byte read.
REQ-010 DATA_OUT_USBBUFF  input  8  buffer read data, valid the cycle after RENA_USBBUFF/RADDR_USBBUFF.
REQ-011 USB_TXE_N  input  1  USB FIFO space flag, low = can accept a byte this cycle.
REQ-012 USB_DATA  output  8  byte to USB FIFO.
REQ-013 USB_WR  output  1  write strobe; byte accepted at the rising CLK edge where USB_WR is high.
REQ-014 BUSY  output  1  high while a half-buffer transfer is in progress.
REQ-015 OVERRUN  output  1  sticky; a half completed while the previous transfer was still running.

Function
REQ-016 BUFFREADY_USBTRANS shall be registered once; a toggle is detected when the registered value differs from its previous sample.
REQ-017 Rising toggle shall start a transfer of addresses 0..HALF_DEPTH-1; falling toggle shall start a transfer of HALF_DEPTH..2*HALF_DEPTH-1.
REQ-018 FSM states: IDLE, XFER, DRAIN; IDLE->XFER on toggle with ENA high; XFER->DRAIN once all HALF_DEPTH reads are issued; DRAIN->IDLE on the edge accepting the last byte.
REQ-019 Reads shall be issued in ascending address order, one per cycle at most, only while holding-FIFO occupancy plus reads in flight is below 2.
REQ-020 Returned data shall be pushed into a 2-entry holding FIFO; USB_DATA shall be the FIFO head.
REQ-021 USB_WR shall equal (FIFO non-empty AND USB_TXE_N low); no byte shall be lost or duplicated when USB_TXE_N toggles on any cycle.
REQ-022 With USB_TXE_N held low, the first USB_WR shall occur no later than 3 cycles after the toggle-detect edge; thereafter one byte per cycle.
REQ-023 BUSY shall be high from the toggle-detect edge until the edge accepting byte HALF_DEPTH.
REQ-024 Toggle detected while BUSY: OVERRUN shall set; the running transfer shall complete unchanged; the new half shall be dropped.
REQ-025 Simultaneous last-byte acceptance and new toggle: the new transfer shall start and OVERRUN shall not set.
REQ-026 ENA low mid-transfer: next edge shall return to IDLE, flush FIFO, drop in-flight read, clear BUSY; OVERRUN retained; toggles ignored while ENA low.
REQ-027 Read address arithmetic shall be ADDR_W bits; the upper-half transfer shall end at 255 without wrapping into 0.

Reset
REQ-028 RST high shall asynchronously force: state IDLE, RADDR_USBBUFF 0, RENA_USBBUFF 0, USB_DATA 0, USB_WR 0, BUSY 0, OVERRUN 0, FIFO empty, sampled flag 0.
REQ-029 After RST release, a BUFFREADY_USBTRANS already high shall be detected as a rising toggle.
REQ-030 RST is the only clear for OVERRUN.

Structure
REQ-031 HALF_DEPTH, ADDR_W, data width 8 and the FSM state encoding shall live in shared package usb_buff_pkg.
REQ-032 The 2-entry holding FIFO shall be sub-module usb_skid_fifo; the FSM and address counter stay in usb_buff_reader.

Verification
REQ-033 BUFFREADY 0->1, USB_TXE_N low, RAM = address -> USB_DATA 0x00..0x7F on 128 consecutive USB_WR, BUSY then low.
REQ-034 BUFFREADY 1->0 -> bytes 0x80..0xFF in order, RADDR_USBBUFF never wraps to 0x00.
REQ-035 USB_TXE_N high on every 3rd cycle and for a 10-cycle burst -> exactly 128 bytes, in order, none repeated.
REQ-036 Second toggle at byte 40 of a transfer -> OVERRUN=1, 128 bytes of first half only, then IDLE.
REQ-037 ENA low at byte 64 -> BUSY=0, USB_WR=0 next cycle; new toggle after ENA high -> full 128-byte transfer.
REQ-038 RST asserted mid-transfer -> all outputs 0 immediately, no USB_WR until next toggle.
